// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel byte receiver with comma-based byte alignment.
// In SEARCH it counts consecutive byte-aligned commas. Once COMMA_COUNT of them
// arrive, it locks the byte phase. From then on it delivers every completed byte
// until the next reset.
module serial_paralelo_rx #(
   parameter logic [7:0]  COMMA       = 8'hBC,
   parameter int unsigned COMMA_COUNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enb,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active,
   output logic       comma_det
);

   typedef enum logic {StSearch, StAligned} state_t;

   localparam logic [3:0] CcTarget = 4'(COMMA_COUNT);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_sr, w_sr_nxt;
   logic [2:0] r_bc, w_bc_nxt;
   logic [3:0] r_cc, w_cc_nxt;
   logic [7:0] r_data, w_data_nxt;
   logic       r_valid, w_valid_nxt;
   logic       r_comma, w_comma_nxt;

   logic [7:0] w_s;
   logic       w_bound;
   logic       w_is_comma;

   assign w_s        = {r_sr[6:0], serial_in};
   assign w_bound    = (r_bc == 3'd7);
   assign w_is_comma = (w_s == COMMA);

   // Next-state: bit shifting, comma counting, alignment and byte delivery.
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_bc_nxt    = r_bc;
      w_cc_nxt    = r_cc;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_comma_nxt = 1'b0;
      if (enb) begin
         w_sr_nxt = w_s;
         w_bc_nxt = r_bc + 3'd1;
         case (r_state)
            StSearch: begin
               if (w_is_comma) begin
                  // Any comma, including a sliding one, sets the byte phase.
                  w_bc_nxt = 3'd0;
                  if (w_bound && (r_cc != 4'd0)) begin
                     w_cc_nxt = r_cc + 4'd1;
                  end else begin
                     w_cc_nxt = 4'd1;
                  end
                  if (w_cc_nxt == CcTarget) begin
                     w_state_nxt = StAligned;
                  end
               end else if (w_bound) begin
                  w_cc_nxt = 4'd0;
               end
            end
            StAligned: begin
               // The byte phase is locked, so sliding comma matches are ignored here.
               if (w_bound) begin
                  w_data_nxt  = w_s;
                  w_valid_nxt = !w_is_comma;
                  w_comma_nxt = w_is_comma;
               end
            end
            default: w_state_nxt = StSearch;
         endcase
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StSearch;
         r_sr    <= 8'h00;
         r_bc    <= 3'd0;
         r_cc    <= 4'd0;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_comma <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_bc    <= w_bc_nxt;
         r_cc    <= w_cc_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_comma <= w_comma_nxt;
      end
   end

   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign comma_det = r_comma;
   assign active    = (r_state == StAligned);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx.
// It checks two instances, one with COMMA_COUNT=4 and one with COMMA_COUNT=1,
// against a bit-history reference model on every cycle.
module tb_serial_paralelo_rx;

   logic       clk = 1'b0;
   logic       reset, enb, serial_in;
   logic [7:0] d0, d1;
   logic       v0, v1, a0, a1, c0, c1;

   always #5 clk = ~clk;

   serial_paralelo_rx u_dut0 (
      .clk(clk), .reset(reset), .enb(enb), .serial_in(serial_in),
      .data_out(d0), .valid_out(v0), .active(a0), .comma_det(c0)
   );

   serial_paralelo_rx #(.COMMA(8'hBC), .COMMA_COUNT(1)) u_dut1 (
      .clk(clk), .reset(reset), .enb(enb), .serial_in(serial_in),
      .data_out(d1), .valid_out(v1), .active(a1), .comma_det(c1)
   );

   int n_ck  = 0;
   int n_err = 0;

   // Reference model: the enabled bits received since reset, plus the index of the
   // last comma seen in SEARCH. Byte boundaries fall every 8 bits after that index.
   bit         q[$];
   int         m_anchor[2];
   int         m_cc[2];
   bit         m_al[2];
   logic [7:0] m_data[2];
   bit         m_v[2];
   bit         m_c[2];
   int         cc_req[2] = '{4, 1};
   int         v0_cnt, c0_cnt;

   task automatic check_val(input string tag, input int got, input int exp);
      n_ck++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] last8();
      logic [7:0] w = 8'h00;
      for (int j = 0; j < 8; j++) begin
         int idx = q.size() - 8 + j;
         w = {w[6:0], (idx >= 0) ? q[idx] : 1'b0};
      end
      return w;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit b);
      logic [7:0] w;
      int         n;
      bit         bound;
      for (int k = 0; k < 2; k++) begin
         m_v[k] = 1'b0;
         m_c[k] = 1'b0;
      end
      if (r) begin
         q.delete();
         for (int k = 0; k < 2; k++) begin
            m_anchor[k] = 0; m_cc[k] = 0; m_al[k] = 1'b0; m_data[k] = 8'h00;
         end
      end else if (e) begin
         q.push_back(b);
         n = q.size();
         w = last8();
         for (int k = 0; k < 2; k++) begin
            bound = ((n - m_anchor[k]) % 8) == 0;
            if (!m_al[k]) begin
               if (w == 8'hBC) begin
                  m_cc[k]     = (bound && m_cc[k] > 0) ? m_cc[k] + 1 : 1;
                  m_anchor[k] = n;
                  if (m_cc[k] == cc_req[k]) m_al[k] = 1'b1;
               end else if (bound) begin
                  m_cc[k] = 0;
               end
            end else if (bound) begin
               m_data[k] = w;
               m_v[k]    = (w != 8'hBC);
               m_c[k]    = (w == 8'hBC);
            end
         end
      end
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge,
   // and compare at the next falling edge.
   task automatic step(input bit e, input bit b, input bit r);
      enb = e; serial_in = b; reset = r;
      @(posedge clk);
      model_edge(r, e, b);
      @(negedge clk);
      check_val("data0",   int'(d0), int'(m_data[0]));
      check_val("valid0",  int'(v0), int'(m_v[0]));
      check_val("active0", int'(a0), int'(m_al[0]));
      check_val("comma0",  int'(c0), int'(m_c[0]));
      check_val("data1",   int'(d1), int'(m_data[1]));
      check_val("valid1",  int'(v1), int'(m_v[1]));
      check_val("active1", int'(a1), int'(m_al[1]));
      check_val("comma1",  int'(c1), int'(m_c[1]));
      v0_cnt += int'(v0);
      c0_cnt += int'(c0);
   endtask

   task automatic send_byte(input logic [7:0] x);
      for (int i = 7; i >= 0; i--) step(1'b1, x[i], 1'b0);
   endtask

   // Byte with random enable gaps between its bits.
   task automatic send_byte_gappy(input logic [7:0] x);
      for (int i = 7; i >= 0; i--) begin
         while ($urandom_range(4) == 0) step(1'b0, 1'($urandom), 1'b0);
         step(1'b1, x[i], 1'b0);
      end
   endtask

   task automatic do_reset();
      step(1'($urandom), 1'($urandom), 1'b1);
      step(1'($urandom), 1'($urandom), 1'b1);
   endtask

   initial begin
      reset = 1'b1; enb = 1'b0; serial_in = 1'b0;
      @(negedge clk);
      do_reset();
      check_val("rst_data",   int'(d0), 0);
      check_val("rst_active", int'(a0), 0);
      check_val("rst_valid",  int'(v0), 0);

      // Three random bits, then four commas and two data bytes.
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
      v0_cnt = 0;
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      check_val("s28_active_pre", int'(a0), 0);
      send_byte(8'hBC);
      check_val("s28_active", int'(a0), 1);
      send_byte(8'h5A);
      check_val("s28_d5a", int'(d0), 8'h5A);
      send_byte(8'hC3);
      check_val("s28_dc3", int'(d0), 8'hC3);
      check_val("s28_vcnt", v0_cnt, 2);

      // A broken comma group restarts the count.
      do_reset();
      v0_cnt = 0;
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      send_byte(8'h00);
      check_val("s29_active_mid", int'(a0), 0);
      for (int i = 0; i < 4; i++) send_byte(8'hBC);
      check_val("s29_active", int'(a0), 1);
      send_byte(8'h11);
      check_val("s29_d11", int'(d0), 8'h11);
      check_val("s29_vcnt", v0_cnt, 1);

      // A comma inside aligned data.
      v0_cnt = 0; c0_cnt = 0;
      send_byte(8'h22);
      send_byte(8'hBC);
      check_val("s30_dbc", int'(d0), 8'hBC);
      check_val("s30_cdet", int'(c0), 1);
      send_byte(8'h33);
      check_val("s30_vcnt", v0_cnt, 2);
      check_val("s30_ccnt", c0_cnt, 1);

      // An enable gap in the middle of a byte.
      v0_cnt = 0;
      for (int i = 7; i >= 4; i--) step(1'b1, 1'(8'hA5 >> i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'b0);
      for (int i = 3; i >= 0; i--) step(1'b1, 1'(8'hA5 >> i), 1'b0);
      check_val("s31_da5", int'(d0), 8'hA5);
      check_val("s31_vcnt", v0_cnt, 1);

      // Reset in the middle of a byte while aligned.
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
      step(1'($urandom), 1'($urandom), 1'b1);
      check_val("s32_active", int'(a0), 0);
      check_val("s32_data", int'(d0), 0);
      v0_cnt = 0;
      send_byte(8'h00);
      for (int i = 0; i < 4; i++) send_byte(8'hBC);
      check_val("s32_vcnt_pre", v0_cnt, 0);
      send_byte(8'h77);
      check_val("s32_vcnt", v0_cnt, 1);

      // COMMA_COUNT=1 instance.
      do_reset();
      send_byte(8'hBC);
      check_val("s33_active1", int'(a1), 1);
      check_val("s33_active0", int'(a0), 0);
      send_byte(8'h7E);
      check_val("s33_d7e", int'(d1), 8'h7E);

      // Random traffic: comma bursts, random bytes, phase slips, enable gaps, resets.
      do_reset();
      for (int blk = 0; blk < 300; blk++) begin
         case ($urandom_range(9))
            0, 1, 2: begin
               int nc = int'($urandom_range(6, 3));
               for (int i = 0; i < nc; i++) send_byte_gappy(8'hBC);
            end
            3, 4, 5, 6: send_byte_gappy(8'($urandom));
            7, 8: begin
               int nb = int'($urandom_range(3, 1));
               for (int i = 0; i < nb; i++) step(1'($urandom), 1'($urandom), 1'b0);
            end
            default: if ($urandom_range(3) == 0) step(1'($urandom), 1'($urandom), 1'b1);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_ck);
      $finish;
   end

endmodule
